// File: rtl/elixirchip_es1_spu_loop_ctl.sv
// ---------------------------------------------------------------------------
// elixirchip_es1_spu_loop_ctl
//
// Sequencer for a chain of SPU op stages. A start request launches a job:
// one clear cycle, then N valid cycles tagged with first/last/index, then a
// drain wait of LATENCY cycles so the chain empties, and finally a one-cycle
// done pulse. m_clear/m_valid feed s_clear/s_valid of the first op stage.
//
// Parameters
//   LATENCY     total pipeline latency (cke cycles) of the controlled chain
//   COUNT_BITS  width of the iteration count and index
//   DEVICE      device name, passed through
//   SIMULATION  simulation flag
//   DEBUG       debug flag
//
// Ports
//   clk      in   clock
//   reset    in   synchronous reset, active-high
//   cke      in   clock enable; all state advances only when cke=1
//   s_start  in   start request, accepted when s_ready=1 and cke=1
//   s_count  in   iteration count, sampled at accept (0 = no iterations)
//   s_ready  out  1 only in IDLE
//   m_clear  out  clear strobe to the op chain
//   m_valid  out  valid strobe to the op chain
//   m_first  out  m_valid and index==0
//   m_last   out  m_valid and index==count-1
//   m_index  out  current iteration index (0 outside RUN)
//   busy     out  1 in every state except IDLE
//   done     out  one-cycle completion pulse
//
// All outputs are decoded from registered state only, so they hold while
// cke=0 and never combinationally follow the s_* inputs.
// ---------------------------------------------------------------------------
module elixirchip_es1_spu_loop_ctl #(
  parameter int LATENCY    = 1,
  parameter int COUNT_BITS = 16,
  parameter     DEVICE     = "RTL",
  parameter     SIMULATION = "false",
  parameter     DEBUG      = "false"
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cke,
  input  logic                  s_start,
  input  logic [COUNT_BITS-1:0] s_count,
  output logic                  s_ready,
  output logic                  m_clear,
  output logic                  m_valid,
  output logic                  m_first,
  output logic                  m_last,
  output logic [COUNT_BITS-1:0] m_index,
  output logic                  busy,
  output logic                  done
);

  // A negative chain latency has no meaning; stop elaboration with context.
  if (LATENCY < 0) begin : g_bad_latency
    $error("elixirchip_es1_spu_loop_ctl (%s, sim=%s, dbg=%s): LATENCY must be >= 0",
           DEVICE, SIMULATION, DEBUG);
  end

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CLEAR = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_DRAIN = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Drain counter just wide enough to hold LATENCY.
  localparam int                 DRAIN_W    = (LATENCY < 2) ? 1 : $clog2(LATENCY + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(LATENCY);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);

  logic [2:0]            state_q, state_d;
  logic [COUNT_BITS-1:0] index_q, index_d;
  logic [COUNT_BITS-1:0] last_q,  last_d;
  logic [DRAIN_W-1:0]    drain_q, drain_d;

  logic                  run_last;

  // Comparing against a latched count-1 keeps the RUN exit a plain equality
  // and lets a count of all-ones walk the index to its top without wrapping.
  assign run_last = (index_q == last_q);

  always_comb begin
    state_d = state_q;
    index_d = index_q;
    last_d  = last_q;
    drain_d = drain_q;
    case (state_q)
      ST_IDLE: begin
        if (s_start) begin
          last_d  = s_count - 1'b1;
          index_d = '0;
          state_d = (s_count == '0) ? ST_DONE : ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        index_d = '0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (run_last) begin
          index_d = '0;
          drain_d = DRAIN_INIT;
          // With no chain latency there is nothing to drain.
          state_d = (LATENCY == 0) ? ST_DONE : ST_DRAIN;
        end else begin
          index_d = index_q + 1'b1;
        end
      end
      ST_DRAIN: begin
        // The counter is loaded with LATENCY, so leaving on 1 makes done
        // land exactly LATENCY+1 cycles after the last valid beat.
        if (drain_q <= DRAIN_ONE) begin
          state_d = ST_DONE;
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State / counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      index_q <= '0;
      drain_q <= '0;
    end else if (cke) begin
      state_q <= state_d;
      index_q <= index_d;
      drain_q <= drain_d;
    end
  end

  // The latched last index is only observed while m_valid is high, so it
  // needs no reset.
  always_ff @(posedge clk) begin
    if (cke) begin
      last_q <= last_d;
    end
  end

  // Output decode
  assign s_ready = (state_q == ST_IDLE);
  assign busy    = (state_q != ST_IDLE);
  assign m_clear = (state_q == ST_CLEAR);
  assign m_valid = (state_q == ST_RUN);
  assign done    = (state_q == ST_DONE);
  assign m_index = m_valid ? index_q : '0;
  assign m_first = m_valid && (index_q == '0);
  assign m_last  = m_valid && run_last;

endmodule

// File: tb/tb_elixirchip_es1_spu_loop_ctl.sv
module tb_elixirchip_es1_spu_loop_ctl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cke;
  logic        s_start;
  logic [15:0] s_count;

  // Instance slot 0: LATENCY=0, slot 1: LATENCY=1, slot 2: LATENCY=3
  logic [2:0]  rdy, clr, vld, fst, lst, bsy, dn;
  logic [15:0] idx0, idx1, idx3;

  int total = 0;
  int fails = 0;
  int beats;

  always #5 clk = ~clk;

  elixirchip_es1_spu_loop_ctl #(.LATENCY(0), .COUNT_BITS(16)) u_lat0 (
    .clk(clk), .reset(reset), .cke(cke), .s_start(s_start), .s_count(s_count),
    .s_ready(rdy[0]), .m_clear(clr[0]), .m_valid(vld[0]), .m_first(fst[0]),
    .m_last(lst[0]), .m_index(idx0), .busy(bsy[0]), .done(dn[0]));

  elixirchip_es1_spu_loop_ctl #(.LATENCY(1), .COUNT_BITS(16)) u_lat1 (
    .clk(clk), .reset(reset), .cke(cke), .s_start(s_start), .s_count(s_count),
    .s_ready(rdy[1]), .m_clear(clr[1]), .m_valid(vld[1]), .m_first(fst[1]),
    .m_last(lst[1]), .m_index(idx1), .busy(bsy[1]), .done(dn[1]));

  elixirchip_es1_spu_loop_ctl #(.LATENCY(3), .COUNT_BITS(16)) u_lat3 (
    .clk(clk), .reset(reset), .cke(cke), .s_start(s_start), .s_count(s_count),
    .s_ready(rdy[2]), .m_clear(clr[2]), .m_valid(vld[2]), .m_first(fst[2]),
    .m_last(lst[2]), .m_index(idx3), .busy(bsy[2]), .done(dn[2]));

  // Flag order: {ready, clear, valid, first, last, busy, done}
  localparam logic [6:0] IDLE = 7'b1000000;
  localparam logic [6:0] CLR  = 7'b0100010;
  localparam logic [6:0] VF   = 7'b0011010;
  localparam logic [6:0] VM   = 7'b0010010;
  localparam logic [6:0] VL   = 7'b0010110;
  localparam logic [6:0] VFL  = 7'b0011110;
  localparam logic [6:0] DRN  = 7'b0000010;
  localparam logic [6:0] DNE  = 7'b0000011;

  localparam logic [6:0]  T1  [11] = '{IDLE, CLR, VF, VM, VM, VL, DRN, DRN, DRN, DNE, IDLE};
  localparam logic [15:0] T1I [11] = '{0, 0, 0, 1, 2, 3, 0, 0, 0, 0, 0};
  localparam logic [6:0]  T2  [3]  = '{IDLE, DNE, IDLE};
  localparam logic [6:0]  T3  [5]  = '{IDLE, CLR, VFL, DNE, IDLE};
  localparam logic [6:0]  T4  [10] = '{IDLE, CLR, VF, VM, VL, DRN, DRN, DRN, DNE, IDLE};
  localparam logic [15:0] T4I [10] = '{0, 0, 0, 1, 2, 0, 0, 0, 0, 0};
  localparam logic [6:0]  T5  [9]  = '{IDLE, CLR, VF, VL, DRN, DRN, DRN, DNE, IDLE};
  localparam logic [15:0] T5I [9]  = '{0, 0, 0, 1, 0, 0, 0, 0, 0};
  localparam logic [6:0]  T6  [6]  = '{IDLE, CLR, VF, VL, DRN, DNE};

  function automatic logic [6:0] flags(input int k);
    return {rdy[k], clr[k], vld[k], fst[k], lst[k], bsy[k], dn[k]};
  endfunction

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: flags observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_num(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: value observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    cke     = 1'b1;
    s_start = 1'b0;
    s_count = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state on every instance
    for (int k = 0; k < 3; k++) chk($sformatf("reset_flags[%0d]", k), flags(k), IDLE);
    chk_num("reset_idx0", int'(idx0), 0);
    chk_num("reset_idx3", int'(idx3), 0);

    // 1: LATENCY=3, count=4
    s_start = 1'b1;
    s_count = 16'd4;
    for (int c = 0; c < 11; c++) begin
      chk($sformatf("t1_flags_c%0d", c), flags(2), T1[c]);
      chk_num($sformatf("t1_idx_c%0d", c), int'(idx3), int'(T1I[c]));
      step();
      s_start = 1'b0;
    end
    do_reset();

    // 2: count=0 goes straight to done
    s_start = 1'b1;
    s_count = 16'd0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t2_flags_c%0d", c), flags(2), T2[c]);
      step();
      s_start = 1'b0;
    end
    do_reset();

    // 3: count=1, LATENCY=0
    s_start = 1'b1;
    s_count = 16'd1;
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("t3_flags_c%0d", c), flags(0), T3[c]);
      chk_num($sformatf("t3_idx_c%0d", c), int'(idx0), 0);
      step();
      s_start = 1'b0;
    end
    do_reset();

    // 4: count=3, LATENCY=3, cke high on even cycles only
    s_start = 1'b1;
    s_count = 16'd3;
    beats   = 0;
    for (int c = 0; c < 18; c++) begin
      cke = (c % 2 == 0);
      chk($sformatf("t4_flags_c%0d", c), flags(2), T4[(c + 1) / 2]);
      chk_num($sformatf("t4_idx_c%0d", c), int'(idx3), int'(T4I[(c + 1) / 2]));
      if (vld[2] && cke) beats++;
      step();
      s_start = 1'b0;
    end
    cke = 1'b1;
    chk_num("t4_valid_beats", beats, 3);
    do_reset();

    // 5: count=8, reset during RUN at index 4, then a clean job
    s_start = 1'b1;
    s_count = 16'd8;
    for (int c = 0; c < 6; c++) begin
      step();
      s_start = 1'b0;
    end
    chk("t5_run_before_reset", flags(2), VM);
    chk_num("t5_idx_before_reset", int'(idx3), 4);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_after_reset", flags(2), IDLE);
    chk_num("t5_idx_after_reset", int'(idx3), 0);
    for (int c = 0; c < 12; c++) begin
      step();
      chk($sformatf("t5_quiet_c%0d", c), flags(2), IDLE);
    end
    s_start = 1'b1;
    s_count = 16'd2;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("t5_rerun_c%0d", c), flags(2), T5[c]);
      chk_num($sformatf("t5_rerun_idx_c%0d", c), int'(idx3), int'(T5I[c]));
      step();
      s_start = 1'b0;
    end
    do_reset();

    // 6: start held, count=2 at accept (garbage count while busy), LATENCY=1
    s_start = 1'b1;
    for (int c = 0; c < 13; c++) begin
      s_count = (c % 6 == 0) ? 16'd2 : 16'd7;
      chk($sformatf("t6_flags_c%0d", c), flags(1), T6[c % 6]);
      chk_num($sformatf("t6_idx_c%0d", c), int'(idx1), (c % 6 == 3) ? 1 : 0);
      step();
    end
    s_start = 1'b0;

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
